// File: rtl/crop_norm_pkg.sv
// Shared state encoding and crop clamp limits for the crop/normalize frame sequencer.
package crop_norm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Largest left/top edge that keeps the crop box inside the image.
    function automatic int max_x0(input int in_cols, input int out_cols);
        return in_cols - out_cols;
    endfunction

    function automatic int max_y0(input int in_rows, input int out_rows);
        return in_rows - out_rows;
    endfunction

endpackage

// File: rtl/crop_norm_ctrl_raster_counter.sv
// Column/row raster position of the next pixel beat; clear wins over advance.
module raster_counter #(
    parameter int COLS = 20,
    parameter int ROWS = 20,
    parameter int CW   = $clog2(COLS),
    parameter int RW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] cnt_col,
    output logic [RW-1:0] cnt_row
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (adv) begin
            if (col_q == CW'(COLS - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign cnt_col = col_q;
    assign cnt_row = row_q;

endmodule

// File: rtl/crop_norm_ctrl.sv
// Frame sequencer: ap_start handshake, boundary-applied clamped crop origin,
// raster position tracking, frame counting and RUN watchdog.
module crop_norm_ctrl
    import crop_norm_pkg::*;
#(
    parameter int IN_ROWS        = 20,
    parameter int IN_COLS        = 20,
    parameter int OUT_ROWS       = 10,
    parameter int OUT_COLS       = 10,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       enable,
    input  logic                       cfg_valid,
    input  logic [$clog2(IN_COLS)-1:0] cfg_x0,
    input  logic [$clog2(IN_ROWS)-1:0] cfg_y0,
    input  logic                       pix_tvalid,
    input  logic                       pix_tready,
    output logic                       ap_start,
    input  logic                       ap_ready,
    input  logic                       ap_done,
    output logic [$clog2(IN_COLS)-1:0] crop_x0,
    output logic [$clog2(IN_ROWS)-1:0] crop_y0,
    output logic [$clog2(IN_COLS)-1:0] cnt_col,
    output logic [$clog2(IN_ROWS)-1:0] cnt_row,
    output logic                       busy,
    output logic                       frame_done,
    output logic [15:0]                frame_count,
    output logic                       cfg_clamped,
    output logic                       timeout_err
);

    localparam int XW = $clog2(IN_COLS);
    localparam int YW = $clog2(IN_ROWS);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [XW-1:0] MAX_X   = XW'(max_x0(IN_COLS, OUT_COLS));
    localparam logic [YW-1:0] MAX_Y   = YW'(max_y0(IN_ROWS, OUT_ROWS));
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] pend_x_q, pend_x_d, crop_x_q, crop_x_d, cfg_x_clip;
    logic [YW-1:0] pend_y_q, pend_y_d, crop_y_q, crop_y_d, cfg_y_clip;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          clamped_q, clamped_d;
    logic          tmo_q, tmo_d;
    logic          hs, beat;

    assign cfg_x_clip = (cfg_x0 > MAX_X) ? MAX_X : cfg_x0;
    assign cfg_y_clip = (cfg_y0 > MAX_Y) ? MAX_Y : cfg_y0;
    assign hs         = (state_q == ST_ARM) && ap_ready;
    assign beat       = (state_q == ST_RUN) && pix_tvalid && pix_tready;

    always_comb begin
        state_d   = state_q;
        pend_x_d  = pend_x_q;
        pend_y_d  = pend_y_q;
        crop_x_d  = crop_x_q;
        crop_y_d  = crop_y_q;
        wdog_d    = wdog_q;
        fcnt_d    = fcnt_q;
        clamped_d = clamped_q;
        tmo_d     = tmo_q;

        if (cfg_valid) begin
            pend_x_d = cfg_x_clip;
            pend_y_d = cfg_y_clip;
            if (cfg_x0 > MAX_X || cfg_y0 > MAX_Y)
                clamped_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: if (enable) state_d = ST_ARM;
            ST_ARM: begin
                if (hs) begin
                    // A write landing on the handshake cycle goes straight to this frame.
                    crop_x_d = cfg_valid ? cfg_x_clip : pend_x_q;
                    crop_y_d = cfg_valid ? cfg_y_clip : pend_y_q;
                    wdog_d   = '0;
                    state_d  = ST_RUN;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                wdog_d = wdog_q + WW'(1);
                if (ap_done) begin
                    fcnt_d  = fcnt_q + 16'd1;
                    state_d = ST_DONE;
                end else if (wdog_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = enable ? ST_ARM : ST_IDLE;
            ST_ERR:  if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= ST_IDLE;
            pend_x_q  <= '0;
            pend_y_q  <= '0;
            crop_x_q  <= '0;
            crop_y_q  <= '0;
            wdog_q    <= '0;
            fcnt_q    <= '0;
            clamped_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_x_q  <= pend_x_d;
            pend_y_q  <= pend_y_d;
            crop_x_q  <= crop_x_d;
            crop_y_q  <= crop_y_d;
            wdog_q    <= wdog_d;
            fcnt_q    <= fcnt_d;
            clamped_q <= clamped_d;
            tmo_q     <= tmo_d;
        end
    end

    raster_counter #(
        .COLS(IN_COLS),
        .ROWS(IN_ROWS),
        .CW  (XW),
        .RW  (YW)
    ) u_raster (
        .clk    (clk),
        .srst   (srst),
        .clr    (hs),
        .adv    (beat),
        .cnt_col(cnt_col),
        .cnt_row(cnt_row)
    );

    assign ap_start    = (state_q == ST_ARM);
    assign busy        = (state_q == ST_ARM) || (state_q == ST_RUN);
    assign frame_done  = (state_q == ST_DONE);
    assign frame_count = fcnt_q;
    assign crop_x0     = crop_x_q;
    assign crop_y0     = crop_y_q;
    assign cfg_clamped = clamped_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_crop_norm_ctrl.sv
// Directed bench: main instance with default watchdog, second instance with a 16-cycle watchdog.
module tb_crop_norm_ctrl;

    logic       clk = 1'b0;
    logic       srst, enable, cfg_valid, pix_tvalid, pix_tready, ap_ready, ap_done;
    logic [4:0] cfg_x0, cfg_y0;
    logic       ap_start, busy, frame_done, cfg_clamped, timeout_err;
    logic [4:0] crop_x0, crop_y0, cnt_col, cnt_row;
    logic [15:0] frame_count;

    logic       en2, rdy2;
    logic       ap_start2, busy2, frame_done2, cfg_clamped2, timeout_err2;
    logic [4:0] crop_x02, crop_y02, cnt_col2, cnt_row2;
    logic [15:0] frame_count2;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_col, exp_row;

    always #5 clk = ~clk;

    crop_norm_ctrl dut (
        .clk(clk), .srst(srst), .enable(enable), .cfg_valid(cfg_valid),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .pix_tvalid(pix_tvalid), .pix_tready(pix_tready),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .crop_x0(crop_x0), .crop_y0(crop_y0), .cnt_col(cnt_col), .cnt_row(cnt_row),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .cfg_clamped(cfg_clamped), .timeout_err(timeout_err)
    );

    crop_norm_ctrl #(.TIMEOUT_CYCLES(16)) dut_wd (
        .clk(clk), .srst(srst), .enable(en2), .cfg_valid(1'b0),
        .cfg_x0(5'd0), .cfg_y0(5'd0), .pix_tvalid(1'b0), .pix_tready(1'b0),
        .ap_start(ap_start2), .ap_ready(rdy2), .ap_done(1'b0),
        .crop_x0(crop_x02), .crop_y0(crop_y02), .cnt_col(cnt_col2), .cnt_row(cnt_row2),
        .busy(busy2), .frame_done(frame_done2), .frame_count(frame_count2),
        .cfg_clamped(cfg_clamped2), .timeout_err(timeout_err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        srst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_x0 = '0; cfg_y0 = '0;
        pix_tvalid = 1'b0; pix_tready = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
        en2 = 1'b0; rdy2 = 1'b0;
        tick(); tick();
        srst = 1'b0;

        check("rst_ap_start", ap_start, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_crop_x0", crop_x0, 0);
        check("rst_cnt", {cnt_row, cnt_col}, 0);
        check("rst_clamped", cfg_clamped, 0);
        check("rst_timeout", timeout_err, 0);

        // Clamp: 15 exceeds 20-10, 4 is in range
        cfg_valid = 1'b1; cfg_x0 = 5'd15; cfg_y0 = 5'd4;
        tick();
        cfg_valid = 1'b0;
        check("clamp_sticky", cfg_clamped, 1);

        enable = 1'b1;
        tick();
        check("start_latency", ap_start, 1);
        check("arm_busy", busy, 1);
        repeat (5) tick();
        check("start_held", ap_start, 1);
        check("crop_before_hs", crop_x0, 0);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        check("run_ap_start", ap_start, 0);
        check("run_busy", busy, 1);
        check("clamp_x0", crop_x0, 10);
        check("clamp_y0", crop_y0, 4);

        // Mid-RUN write must wait for the next frame
        cfg_valid = 1'b1; cfg_x0 = 5'd3; cfg_y0 = 5'd2;
        tick();
        cfg_valid = 1'b0;
        check("midrun_x0_held", crop_x0, 10);
        check("midrun_y0_held", crop_y0, 4);
        check("clamp_stays", cfg_clamped, 1);

        exp_col = 0; exp_row = 0;
        pix_tvalid = 1'b1;
        for (int b = 1; b <= 400; b++) begin
            repeat ($urandom_range(0, 2)) begin
                pix_tready = 1'b0;
                tick();
            end
            pix_tready = 1'b1;
            tick();
            pix_tready = 1'b0;
            exp_col++;
            if (exp_col == 20) begin
                exp_col = 0;
                exp_row = (exp_row == 19) ? 0 : exp_row + 1;
            end
            check("raster_col", cnt_col, exp_col);
            check("raster_row", cnt_row, exp_row);
        end
        pix_tvalid = 1'b0;
        check("raster_wrap", {cnt_row, cnt_col}, 0);

        // Frame 1 end: DONE next cycle, ARM the cycle after
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("f1_frame_done", frame_done, 1);
        check("f1_count", frame_count, 1);
        check("f1_done_no_start", ap_start, 0);
        check("f1_done_crop", crop_x0, 10);
        tick();
        check("f1_restart", ap_start, 1);
        check("f1_pulse_once", frame_done, 0);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        check("f2_crop_x0", crop_x0, 3);
        check("f2_crop_y0", crop_y0, 2);

        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("f2_frame_done", frame_done, 1);
        check("f2_count", frame_count, 2);
        tick();
        check("f2_restart", ap_start, 1);
        // Write on the handshake cycle bypasses pending; y0=12 clamps to 10
        ap_ready = 1'b1; cfg_valid = 1'b1; cfg_x0 = 5'd5; cfg_y0 = 5'd12;
        tick();
        ap_ready = 1'b0; cfg_valid = 1'b0;
        check("bypass_x0", crop_x0, 5);
        check("bypass_y0", crop_y0, 10);

        ap_done = 1'b1;
        tick();
        ap_done = 1'b0; enable = 1'b0;
        check("f3_frame_done", frame_done, 1);
        check("f3_count", frame_count, 3);
        tick();
        check("idle_after_done", busy, 0);
        check("idle_no_start", ap_start, 0);

        ap_done = 1'b1; pix_tvalid = 1'b1; pix_tready = 1'b1;
        tick(); tick();
        ap_done = 1'b0; pix_tvalid = 1'b0; pix_tready = 1'b0;
        check("idle_done_ignored", frame_count, 3);
        check("idle_pix_ignored", {cnt_row, cnt_col}, 0);

        enable = 1'b1;
        tick();
        check("arm_again", ap_start, 1);
        enable = 1'b0;
        tick();
        check("arm_abort", ap_start, 0);
        check("arm_abort_busy", busy, 0);

        // Timeout instance: RUN cycle 16 without ap_done
        en2 = 1'b1;
        tick();
        rdy2 = 1'b1;
        tick();
        rdy2 = 1'b0;
        check("wd_run", busy2, 1);
        repeat (15) tick();
        check("wd_not_yet", timeout_err2, 0);
        check("wd_still_run", busy2, 1);
        tick();
        check("wd_err", timeout_err2, 1);
        check("wd_err_busy", busy2, 0);
        check("wd_err_start", ap_start2, 0);
        tick();
        check("wd_err_holds", timeout_err2, 1);
        en2 = 1'b0;
        tick();
        check("wd_idle_sticky", timeout_err2, 1);
        en2 = 1'b1;
        tick();
        check("wd_rearm", ap_start2, 1);
        en2 = 1'b0;

        // srst mid-frame on the main instance
        enable = 1'b1;
        tick();
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        pix_tvalid = 1'b1; pix_tready = 1'b1;
        tick(); tick(); tick();
        pix_tvalid = 1'b0; pix_tready = 1'b0;
        check("pre_srst_col", cnt_col, 3);
        srst = 1'b1;
        tick();
        srst = 1'b0; enable = 1'b0;
        check("srst_busy", busy, 0);
        check("srst_count", frame_count, 0);
        check("srst_crop", {crop_y0, crop_x0}, 0);
        check("srst_cnt", {cnt_row, cnt_col}, 0);
        check("srst_clamped", cfg_clamped, 0);
        check("srst_wd_clear", timeout_err2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
